forward_hazard_ctrl: RTL and testbench

//  Producer side of the EXE-stage forwarding interface: generates val1_sel, val2_sel and
//  ST_val_sel for the instruction in EXE and the load-use / no-forward stall for ID.

---
 rtl/forward_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_forward_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/forward_hazard_ctrl.sv
// EXE-stage forwarding select and load-use / no-forward stall generator.
// Keeps a private EXE/MEM/WB tag pipeline that mirrors the datapath pipeline registers.
module forward_hazard_ctrl #(
    parameter int unsigned REG_ADDR_LEN  = 5,
    parameter int unsigned FORW_SEL_LEN  = 2,
    parameter int unsigned STALL_CNT_LEN = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     forward_en,
    input  logic                     flush,
    input  logic                     id_valid,
    input  logic [REG_ADDR_LEN-1:0]  id_src1,
    input  logic [REG_ADDR_LEN-1:0]  id_src2,
    input  logic                     id_src2_used,
    input  logic                     id_is_store,
    input  logic [REG_ADDR_LEN-1:0]  id_st_src,
    input  logic [REG_ADDR_LEN-1:0]  id_dest,
    input  logic                     id_wb_en,
    input  logic                     id_mem_read,
    output logic [FORW_SEL_LEN-1:0]  val1_sel,
    output logic [FORW_SEL_LEN-1:0]  val2_sel,
    output logic [FORW_SEL_LEN-1:0]  st_val_sel,
    output logic                     hazard_stall,
    output logic [STALL_CNT_LEN-1:0] stall_count
);

    localparam logic [FORW_SEL_LEN-1:0] SelReg = FORW_SEL_LEN'(0);
    localparam logic [FORW_SEL_LEN-1:0] SelMem = FORW_SEL_LEN'(1);
    localparam logic [FORW_SEL_LEN-1:0] SelWb  = FORW_SEL_LEN'(2);

    logic                     exe_valid_q, exe_wb_en_q, exe_mem_read_q;
    logic [REG_ADDR_LEN-1:0]  exe_dest_q, exe_src1_q, exe_src2_q, exe_st_src_q;
    logic                     exe_src2_used_q, exe_is_store_q;
    logic                     mem_valid_q, mem_wb_en_q;
    logic [REG_ADDR_LEN-1:0]  mem_dest_q;
    logic                     wb_valid_q, wb_wb_en_q;
    logic [REG_ADDR_LEN-1:0]  wb_dest_q;
    logic [STALL_CNT_LEN-1:0] stall_cnt_q, stall_cnt_d;

    logic exe_wr, mem_wr, wb_wr;
    logic exe_hit, mem_hit, bubble;

    function automatic logic writes(input logic wr, input logic [REG_ADDR_LEN-1:0] dest,
                                    input logic [REG_ADDR_LEN-1:0] r);
        return wr && (dest == r) && (r != '0);
    endfunction

    function automatic logic [FORW_SEL_LEN-1:0] sel_for(
        input logic m_wr, input logic [REG_ADDR_LEN-1:0] m_dest,
        input logic w_wr, input logic [REG_ADDR_LEN-1:0] w_dest,
        input logic [REG_ADDR_LEN-1:0] r);
        if (writes(m_wr, m_dest, r)) return SelMem;
        if (writes(w_wr, w_dest, r)) return SelWb;
        return SelReg;
    endfunction

    assign exe_wr = exe_valid_q & exe_wb_en_q;
    assign mem_wr = mem_valid_q & mem_wb_en_q;
    assign wb_wr  = wb_valid_q & wb_wb_en_q;

    always_comb begin
        val1_sel   = SelReg;
        val2_sel   = SelReg;
        st_val_sel = SelReg;
        if (forward_en) begin
            val1_sel = sel_for(mem_wr, mem_dest_q, wb_wr, wb_dest_q, exe_src1_q);
            if (exe_src2_used_q) begin
                val2_sel = sel_for(mem_wr, mem_dest_q, wb_wr, wb_dest_q, exe_src2_q);
            end
            if (exe_is_store_q) begin
                st_val_sel = sel_for(mem_wr, mem_dest_q, wb_wr, wb_dest_q, exe_st_src_q);
            end
        end
    end

    // WB is never a stall source: the register file is written in the first half-cycle.
    always_comb begin
        exe_hit = writes(exe_wr, exe_dest_q, id_src1)
                | (id_src2_used & writes(exe_wr, exe_dest_q, id_src2))
                | (id_is_store  & writes(exe_wr, exe_dest_q, id_st_src));
        mem_hit = writes(mem_wr, mem_dest_q, id_src1)
                | (id_src2_used & writes(mem_wr, mem_dest_q, id_src2))
                | (id_is_store  & writes(mem_wr, mem_dest_q, id_st_src));
        if (forward_en) begin
            hazard_stall = id_valid & exe_mem_read_q & exe_hit;
        end else begin
            hazard_stall = id_valid & (exe_hit | mem_hit);
        end
    end

    assign bubble = !id_valid || hazard_stall || flush;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_LEN'(1);
        end
    end

    assign stall_count = stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_valid_q     <= 1'b0;
            exe_wb_en_q     <= 1'b0;
            exe_mem_read_q  <= 1'b0;
            exe_dest_q      <= '0;
            exe_src1_q      <= '0;
            exe_src2_q      <= '0;
            exe_src2_used_q <= 1'b0;
            exe_is_store_q  <= 1'b0;
            exe_st_src_q    <= '0;
            mem_valid_q     <= 1'b0;
            mem_wb_en_q     <= 1'b0;
            mem_dest_q      <= '0;
            wb_valid_q      <= 1'b0;
            wb_wb_en_q      <= 1'b0;
            wb_dest_q       <= '0;
            stall_cnt_q     <= '0;
        end else begin
            wb_valid_q  <= mem_valid_q;
            wb_wb_en_q  <= mem_wb_en_q;
            wb_dest_q   <= mem_dest_q;
            mem_valid_q <= exe_valid_q;
            mem_wb_en_q <= exe_wb_en_q;
            mem_dest_q  <= exe_dest_q;
            stall_cnt_q <= stall_cnt_d;
            // A bubble clears its sources too, so it never requests forwarding.
            if (bubble) begin
                exe_valid_q     <= 1'b0;
                exe_wb_en_q     <= 1'b0;
                exe_mem_read_q  <= 1'b0;
                exe_dest_q      <= '0;
                exe_src1_q      <= '0;
                exe_src2_q      <= '0;
                exe_src2_used_q <= 1'b0;
                exe_is_store_q  <= 1'b0;
                exe_st_src_q    <= '0;
            end else begin
                exe_valid_q     <= 1'b1;
                exe_wb_en_q     <= id_wb_en;
                exe_mem_read_q  <= id_mem_read;
                exe_dest_q      <= id_dest;
                exe_src1_q      <= id_src1;
                exe_src2_q      <= id_src2;
                exe_src2_used_q <= id_src2_used;
                exe_is_store_q  <= id_is_store;
                exe_st_src_q    <= id_st_src;
            end
        end
    end

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Scoreboard bench for forward_hazard_ctrl: directed instruction sequences push expected
// outputs; a negedge monitor pops and compares. A 4-bit-counter copy checks saturation.
module tb_forward_hazard_ctrl;

    typedef struct packed {
        logic       v;
        logic [4:0] s1;
        logic [4:0] s2;
        logic       u2;
        logic       st;
        logic [4:0] ss;
        logic [4:0] d;
        logic       we;
        logic       mr;
    } ins_t;

    typedef struct {
        logic [1:0]  v1;
        logic [1:0]  v2;
        logic [1:0]  sv;
        logic        stl;
        logic [15:0] cnt;
        logic [3:0]  cnts;
        string       nm;
    } exp_t;

    logic clk, rst, forward_en, flush, id_valid, id_src2_used, id_is_store, id_wb_en, id_mem_read;
    logic [4:0] id_src1, id_src2, id_st_src, id_dest;
    logic [1:0] val1_sel, val2_sel, st_val_sel, val1_sel_s, val2_sel_s, st_val_sel_s;
    logic hazard_stall, hazard_stall_s;
    logic [15:0] stall_count;
    logic [3:0] stall_count_s;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_err = 0;

    forward_hazard_ctrl dut (
        .clk(clk), .rst(rst), .forward_en(forward_en), .flush(flush), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_src2_used(id_src2_used),
        .id_is_store(id_is_store), .id_st_src(id_st_src), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .val1_sel(val1_sel),
        .val2_sel(val2_sel), .st_val_sel(st_val_sel), .hazard_stall(hazard_stall),
        .stall_count(stall_count)
    );

    forward_hazard_ctrl #(.STALL_CNT_LEN(4)) dut_s (
        .clk(clk), .rst(rst), .forward_en(forward_en), .flush(flush), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_src2_used(id_src2_used),
        .id_is_store(id_is_store), .id_st_src(id_st_src), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .val1_sel(val1_sel_s),
        .val2_sel(val2_sel_s), .st_val_sel(st_val_sel_s), .hazard_stall(hazard_stall_s),
        .stall_count(stall_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ins_t nop();
        return '0;
    endfunction

    function automatic ins_t alu(input logic [4:0] d, input logic [4:0] s1,
                                 input logic [4:0] s2);
        ins_t i = '0;
        i.v = 1'b1; i.d = d; i.s1 = s1; i.s2 = s2; i.u2 = 1'b1; i.we = 1'b1;
        return i;
    endfunction

    function automatic ins_t ld(input logic [4:0] d, input logic [4:0] base);
        ins_t i = '0;
        i.v = 1'b1; i.d = d; i.s1 = base; i.we = 1'b1; i.mr = 1'b1;
        return i;
    endfunction

    function automatic ins_t st(input logic [4:0] base, input logic [4:0] data);
        ins_t i = '0;
        i.v = 1'b1; i.s1 = base; i.st = 1'b1; i.ss = data;
        return i;
    endfunction

    task automatic apply(input ins_t i, input logic fe, input logic fl);
        id_valid = i.v; id_src1 = i.s1; id_src2 = i.s2; id_src2_used = i.u2;
        id_is_store = i.st; id_st_src = i.ss; id_dest = i.d; id_wb_en = i.we;
        id_mem_read = i.mr; forward_en = fe; flush = fl;
    endtask

    task automatic push(input logic [1:0] v1, input logic [1:0] v2, input logic [1:0] sv,
                        input logic stl, input int cnt, input string nm);
        exp_t e;
        e.v1 = v1; e.v2 = v2; e.sv = sv; e.stl = stl; e.cnt = 16'(cnt);
        e.cnts = (cnt > 15) ? 4'hF : 4'(cnt);
        e.nm = nm;
        exp_q.push_back(e);
    endtask

    task automatic step(input ins_t i, input logic fe, input logic fl, input logic [1:0] v1,
                        input logic [1:0] v2, input logic [1:0] sv, input logic stl,
                        input int cnt, input string nm);
        @(posedge clk);
        #1;
        apply(i, fe, fl);
        push(v1, v2, sv, stl, cnt, nm);
    endtask

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.nm, "val1_sel", 32'(val1_sel), 32'(e.v1));
            chk(e.nm, "val2_sel", 32'(val2_sel), 32'(e.v2));
            chk(e.nm, "st_val_sel", 32'(st_val_sel), 32'(e.sv));
            chk(e.nm, "hazard_stall", 32'(hazard_stall), 32'(e.stl));
            chk(e.nm, "stall_count", 32'(stall_count), 32'(e.cnt));
            chk(e.nm, "small.sels", 32'({val1_sel_s, val2_sel_s, st_val_sel_s}),
                32'({e.v1, e.v2, e.sv}));
            chk(e.nm, "small.hazard_stall", 32'(hazard_stall_s), 32'(e.stl));
            chk(e.nm, "small.stall_count", 32'(stall_count_s), 32'(e.cnts));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        apply(nop(), 1'b1, 1'b0);
        step(nop(), 1'b1, 1'b0, 0, 0, 0, 0, 0, "reset");
        @(posedge clk);
        #1 rst = 1'b1;
        step(nop(), 1'b1, 1'b0, 0, 0, 0, 0, 0, "idle");

        // ADD r3; ADD r4<-r3,r5
        step(alu(3, 1, 2), 1'b1, 1'b0, 0, 0, 0, 0, 0, "t1_a");
        step(alu(4, 3, 5), 1'b1, 1'b0, 0, 0, 0, 0, 0, "t1_b");
        step(nop(),        1'b1, 1'b0, 1, 0, 0, 0, 0, "t1_fwd_mem");

        // ADD r3; NOP; SUB r6<-r1,r3, then r3 in both MEM and WB
        step(alu(3, 1, 2), 1'b1, 1'b0, 0, 0, 0, 0, 0, "t2_a");
        step(nop(),        1'b1, 1'b0, 0, 0, 0, 0, 0, "t2_b");
        step(alu(6, 1, 3), 1'b1, 1'b0, 0, 0, 0, 0, 0, "t2_c");
        step(nop(),        1'b1, 1'b0, 0, 2, 0, 0, 0, "t2_fwd_wb");
        step(alu(3, 1, 1), 1'b1, 1'b0, 0, 0, 0, 0, 0, "t2_d");
        step(alu(3, 2, 2), 1'b1, 1'b0, 0, 0, 0, 0, 0, "t2_e");
        step(alu(6, 1, 3), 1'b1, 1'b0, 0, 0, 0, 0, 0, "t2_f");
        step(nop(),        1'b1, 1'b0, 0, 1, 0, 0, 0, "t2_mem_wins");

        // Load-use: one stall, then the load result comes from WB
        step(ld(7, 1),     1'b1, 1'b0, 0, 0, 0, 0, 0, "t3_ld");
        step(alu(8, 7, 7), 1'b1, 1'b0, 0, 0, 0, 1, 0, "t3_stall");
        step(alu(8, 7, 7), 1'b1, 1'b0, 0, 0, 0, 0, 1, "t3_release");
        step(nop(),        1'b1, 1'b0, 2, 2, 0, 0, 1, "t3_fwd");

        // Store data: r0 never forwarded, r2 forwarded from MEM
        step(alu(0, 1, 2), 1'b1, 1'b0, 0, 0, 0, 0, 1, "t4_a");
        step(st(1, 0),     1'b1, 1'b0, 0, 0, 0, 0, 1, "t4_b");
        step(alu(2, 1, 1), 1'b1, 1'b0, 0, 0, 0, 0, 1, "t4_r0_not_fwd");
        step(st(1, 2),     1'b1, 1'b0, 0, 0, 0, 0, 1, "t4_c");
        step(nop(),        1'b1, 1'b0, 0, 0, 1, 0, 1, "t4_st_fwd");

        // forward_en=0 masks an otherwise forwarded select
        step(alu(5, 1, 1), 1'b1, 1'b0, 0, 0, 0, 0, 1, "fe_a");
        step(alu(9, 5, 1), 1'b1, 1'b0, 0, 0, 0, 0, 1, "fe_b");
        step(nop(),        1'b0, 1'b0, 0, 0, 0, 0, 1, "fe_off_mask");
        step(nop(),        1'b1, 1'b0, 0, 0, 0, 0, 1, "fe_drain");

        // No-forward mode: two stall cycles
        step(alu(3, 1, 2), 1'b0, 1'b0, 0, 0, 0, 0, 1, "t5_a");
        step(alu(4, 3, 1), 1'b0, 1'b0, 0, 0, 0, 1, 1, "t5_stall1");
        step(alu(4, 3, 1), 1'b0, 1'b0, 0, 0, 0, 1, 2, "t5_stall2");
        step(alu(4, 3, 1), 1'b0, 1'b0, 0, 0, 0, 0, 3, "t5_release");
        step(nop(),        1'b1, 1'b0, 0, 0, 0, 0, 3, "t5_exe");

        // Flush turns the entering instruction into a bubble
        step(alu(3, 1, 1), 1'b1, 1'b1, 0, 0, 0, 0, 3, "fl_a");
        step(alu(4, 3, 1), 1'b1, 1'b0, 0, 0, 0, 0, 3, "fl_b");
        step(nop(),        1'b1, 1'b0, 0, 0, 0, 0, 3, "flush_bubble");

        // Flush together with a load-use stall: still exactly one bubble
        step(ld(7, 1),     1'b1, 1'b0, 0, 0, 0, 0, 3, "fs_ld");
        step(alu(8, 7, 7), 1'b1, 1'b1, 0, 0, 0, 1, 3, "fs_stall");
        step(alu(8, 7, 7), 1'b1, 1'b0, 0, 0, 0, 0, 4, "fs_release");
        step(nop(),        1'b1, 1'b0, 2, 2, 0, 0, 4, "fs_fwd");

        // Async reset asserted while a load-use stall is active
        step(ld(7, 1), 1'b1, 1'b0, 0, 0, 0, 0, 4, "t6_ld");
        @(posedge clk);
        #1;
        apply(alu(8, 7, 1), 1'b1, 1'b0);
        #1 rst = 1'b0;
        push(0, 0, 0, 0, 0, "t6_reset_mid_stall");
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply(nop(), 1'b0, 1'b0);

        // 20 stalls: full-width counter reads 20, 4-bit copy saturates at 15
        for (int k = 0; k < 10; k++) begin
            step(alu(3, 3, 1), 1'b0, 1'b0, 0, 0, 0, 0, 2 * k,     "sat_enter");
            step(alu(3, 3, 1), 1'b0, 1'b0, 0, 0, 0, 1, 2 * k,     "sat_stall1");
            step(alu(3, 3, 1), 1'b0, 1'b0, 0, 0, 0, 1, 2 * k + 1, "sat_stall2");
        end
        step(nop(), 1'b0, 1'b0, 0, 0, 0, 0, 20, "sat_final");

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
